// File: rtl/eth_10g_rx_st_lane_arbiter.sv
// ---------------------------------------------------------------------------
// eth_10g_rx_st_lane_arbiter
//
// Shares one 72-bit Avalon-ST channel (64 data + 8 control, lane-decoder
// format) between two requesters feeding the 10G MAC RX path. Arbitration is
// round-robin and packet-locked: once a requester wins on a sop beat it keeps
// the channel until its eop beat is accepted. A per-packet beat watchdog
// truncates runaway packets: the beat that reaches MAX_BEATS goes out with
// out_eop and out_error set, and the rest of that packet is silently
// drained. The output is a single registered stage with full ready/valid
// backpressure.
//
// Ports
//   clk                   single clock
//   reset_n               asynchronous active-low reset
//   in0_* / in1_*         requester beats: valid, ready, data, sop, eop
//   out_valid/out_ready   registered output handshake
//   out_data              registered payload
//   out_sop/out_eop       registered packet delimiters
//   out_channel           requester index that produced the output beat
//   out_error             set on a truncated final beat
//   stray_pulse           one-cycle pulse after a non-sop beat is dropped in IDLE
//   trunc_pulse           one-cycle pulse alongside a truncated final beat
// ---------------------------------------------------------------------------
module eth_10g_rx_st_lane_arbiter #(
    parameter int DATA_W    = 72,
    parameter int MAX_BEATS = 1200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_sop,
    input  logic              in0_eop,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_sop,
    input  logic              in1_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_channel,
    output logic              out_error,
    output logic              stray_pulse,
    output logic              trunc_pulse
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              out_channel_q, out_channel_d;
    logic              out_error_q, out_error_d;
    logic              stray_q, stray_d;
    logic              trunc_q, trunc_d;

    logic              in0_rdy, in1_rdy;
    logic              acc0, acc1;
    logic              slot_free;
    logic              req0, req1;
    logic              sel_acc;
    logic [DATA_W-1:0] sel_data;
    logic              sel_sop, sel_eop;
    logic [CNT_W-1:0]  cnt_inc;

    assign slot_free = !out_valid_q || out_ready;
    assign req0      = in0_valid && in0_sop;
    assign req1      = in1_valid && in1_sop;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Ready generation. It depends only on state, grant, output occupancy and
    // the sop flag; never on the requester's own valid. In IDLE a non-sop beat
    // is taken and thrown away, while a sop beat waits out the arbitration
    // bubble. run_q keeps both readies low while reset is applied and for the
    // first cycle after release.
    always_comb begin
        in0_rdy = 1'b0;
        in1_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                in0_rdy = run_q && !in0_sop;
                in1_rdy = run_q && !in1_sop;
            end
            XFER: begin
                if (gnt_q) in1_rdy = slot_free;
                else       in0_rdy = slot_free;
            end
            DROP: begin
                if (gnt_q) in1_rdy = 1'b1;
                else       in0_rdy = 1'b1;
            end
            default: begin
                in0_rdy = 1'b0;
                in1_rdy = 1'b0;
            end
        endcase
    end

    assign acc0     = in0_valid && in0_rdy;
    assign acc1     = in1_valid && in1_rdy;
    assign sel_acc  = gnt_q ? acc1 : acc0;
    assign sel_data = gnt_q ? in1_data : in0_data;
    assign sel_sop  = gnt_q ? in1_sop : in0_sop;
    assign sel_eop  = gnt_q ? in1_eop : in0_eop;

    // Next-state logic for the arbiter FSM, the beat counter and the output
    // register. The output stage drains whenever downstream accepts and no
    // new beat is loaded; an XFER accept overrides that and reloads it.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_channel_d = out_channel_q;
        out_error_d   = out_error_q;
        stray_d       = 1'b0;
        trunc_d       = 1'b0;

        if (out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Any accept in IDLE is a stray non-sop beat; two at once
                // still produce a single pulse.
                stray_d = acc0 || acc1;
                if (req0 || req1) begin
                    gnt_d     = (req0 && req1) ? !rr_last_q : req1;
                    rr_last_d = gnt_d;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (sel_acc) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = sel_data;
                    out_sop_d     = sel_sop;
                    out_eop_d     = sel_eop;
                    out_channel_d = gnt_q;
                    out_error_d   = 1'b0;
                    cnt_d         = cnt_inc;
                    if (sel_eop) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_inc == CNT_W'(MAX_BEATS)) begin
                        // Watchdog hit: close the packet here and drain the rest.
                        out_eop_d   = 1'b1;
                        out_error_d = 1'b1;
                        trunc_d     = 1'b1;
                        cnt_d       = '0;
                        state_d     = DROP;
                    end
                end
            end
            DROP: begin
                if (sel_acc && sel_eop) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. rr_last resets to 1 so requester 0 wins
    // the first contention after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            rr_last_q     <= 1'b1;
            cnt_q         <= '0;
            run_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_channel_q <= 1'b0;
            out_error_q   <= 1'b0;
            stray_q       <= 1'b0;
            trunc_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_last_q     <= rr_last_d;
            cnt_q         <= cnt_d;
            run_q         <= 1'b1;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_channel_q <= out_channel_d;
            out_error_q   <= out_error_d;
            stray_q       <= stray_d;
            trunc_q       <= trunc_d;
        end
    end

    assign in0_ready   = in0_rdy;
    assign in1_ready   = in1_rdy;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_channel = out_channel_q;
    assign out_error   = out_error_q;
    assign stray_pulse = stray_q;
    assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_eth_10g_rx_st_lane_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_10g_rx_st_lane_arbiter
//
// Directed bench for the two-requester RX lane arbiter. Two instances share
// the same stimulus: "dut" with the default watchdog limit, and "dut_t" with
// MAX_BEATS=4 so the truncation path can be reached with a short packet.
// Inputs change just after the falling edge; registered outputs and the
// combinational readies are sampled 1 ns later, well away from the rising
// edge that consumes them.
// ---------------------------------------------------------------------------
module tb_eth_10g_rx_st_lane_arbiter;

    logic        clk;
    logic        reset_n;
    logic        in0_valid, in0_sop, in0_eop;
    logic [71:0] in0_data;
    logic        in1_valid, in1_sop, in1_eop;
    logic [71:0] in1_data;
    logic        out_ready;

    logic        in0_ready, in1_ready;
    logic        out_valid, out_sop, out_eop, out_channel, out_error;
    logic [71:0] out_data;
    logic        stray_pulse, trunc_pulse;

    logic        t_in0_ready, t_in1_ready;
    logic        t_out_valid, t_out_sop, t_out_eop, t_out_channel, t_out_error;
    logic [71:0] t_out_data;
    logic        t_stray_pulse, t_trunc_pulse;

    int          errors;
    int          checks;

    eth_10g_rx_st_lane_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
        .in0_sop(in0_sop), .in0_eop(in0_eop),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .in1_sop(in1_sop), .in1_eop(in1_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_channel(out_channel),
        .out_error(out_error), .stray_pulse(stray_pulse), .trunc_pulse(trunc_pulse)
    );

    eth_10g_rx_st_lane_arbiter #(.DATA_W(72), .MAX_BEATS(4)) dut_t (
        .clk(clk), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_ready(t_in0_ready), .in0_data(in0_data),
        .in0_sop(in0_sop), .in0_eop(in0_eop),
        .in1_valid(in1_valid), .in1_ready(t_in1_ready), .in1_data(in1_data),
        .in1_sop(in1_sop), .in1_eop(in1_eop),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
        .out_sop(t_out_sop), .out_eop(t_out_eop), .out_channel(t_out_channel),
        .out_error(t_out_error), .stray_pulse(t_stray_pulse), .trunc_pulse(t_trunc_pulse)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: stimulus did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Recognisable payload per packet p and beat b.
    function automatic logic [71:0] mkData(input int p, input int b);
        return {8'hC0, 48'h0, 8'(p), 8'(b)};
    endfunction

    // Apply one cycle of inputs after the falling edge, then let them settle.
    task automatic applyStimulus(input logic v0, input logic s0, input logic e0, input logic [71:0] d0,
                                 input logic v1, input logic s1, input logic e1, input logic [71:0] d1,
                                 input logic ordy);
        @(negedge clk);
        in0_valid = v0; in0_sop = s0; in0_eop = e0; in0_data = d0;
        in1_valid = v1; in1_sop = s1; in1_eop = e1; in1_data = d1;
        out_ready = ordy;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
    endtask

    // Drive the granted requester g with a beat while the other requester
    // holds a sop beat of its own (ov=0 leaves the other one idle).
    task automatic presentPair(input logic g, input logic gs, input logic ge, input logic [71:0] gd,
                               input logic ov, input logic [71:0] od);
        if (!g) applyStimulus(1'b1, gs, ge, gd, ov, 1'b1, 1'b0, od, 1'b1);
        else    applyStimulus(ov, 1'b1, 1'b0, od, 1'b1, gs, ge, gd, 1'b1);
    endtask

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Checks a full valid output beat on either instance (t=1 selects dut_t).
    task automatic checkBeat(input logic t, input string tag, input logic [71:0] d,
                             input logic sop, input logic eop, input logic ch, input logic err);
        checkOutput({tag, "_valid"}, t ? t_out_valid   : out_valid,   1'b1);
        checkOutput({tag, "_data"},  t ? t_out_data    : out_data,    d);
        checkOutput({tag, "_sop"},   t ? t_out_sop     : out_sop,     sop);
        checkOutput({tag, "_eop"},   t ? t_out_eop     : out_eop,     eop);
        checkOutput({tag, "_ch"},    t ? t_out_channel : out_channel, ch);
        checkOutput({tag, "_err"},   t ? t_out_error   : out_error,   err);
    endtask

    // Directed sequence: reset, single packet, backpressure, strays, reset
    // mid-packet, round-robin contention, then watchdog truncation.
    initial begin
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        in0_valid = 1'b0; in0_sop = 1'b0; in0_eop = 1'b0; in0_data = '0;
        in1_valid = 1'b0; in1_sop = 1'b0; in1_eop = 1'b0; in1_data = '0;
        out_ready = 1'b1;

        // Reset values, with non-sop beats offered so the readies are exercised.
        applyStimulus(1'b1, 1'b0, 1'b0, 72'h1, 1'b1, 1'b0, 1'b0, 72'h2, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'h1, 1'b1, 1'b0, 1'b0, 72'h2, 1'b1);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, 72'h0);
        checkOutput("rst_out_sop", out_sop, 1'b0);
        checkOutput("rst_out_eop", out_eop, 1'b0);
        checkOutput("rst_out_channel", out_channel, 1'b0);
        checkOutput("rst_out_error", out_error, 1'b0);
        checkOutput("rst_stray", stray_pulse, 1'b0);
        checkOutput("rst_trunc", trunc_pulse, 1'b0);
        checkOutput("rst_in0_ready", in0_ready, 1'b0);
        checkOutput("rst_in1_ready", in1_ready, 1'b0);
        applyIdle();
        reset_n = 1'b1;
        $display("[TB] reset released");

        // Single source, 4-beat packet on in0.
        applyStimulus(1'b1, 1'b1, 1'b0, 72'hA0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkOutput("single_bubble_rdy", in0_ready, 1'b0);
        checkOutput("single_bubble_valid", out_valid, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 72'hA0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkOutput("single_b0_rdy", in0_ready, 1'b1);
        checkOutput("single_b0_rdy1", in1_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hA1, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "single_o0", 72'hA0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hA2, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "single_o1", 72'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 72'hA3, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "single_o2", 72'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyIdle();
        checkBeat(1'b0, "single_o3", 72'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
        applyIdle();
        checkOutput("single_drain", out_valid, 1'b0);

        // Backpressure: out_ready goes 1,0,0,1 during a 5-beat packet.
        applyStimulus(1'b1, 1'b1, 1'b0, 72'hB0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkOutput("bp_bubble_rdy", in0_ready, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 72'hB0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkOutput("bp_b0_rdy", in0_ready, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hB1, 1'b0, 1'b0, 1'b0, 72'h0, 1'b0);
        checkBeat(1'b0, "bp_stall1", 72'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_stall1_rdy", in0_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hB1, 1'b0, 1'b0, 1'b0, 72'h0, 1'b0);
        checkBeat(1'b0, "bp_stall2", 72'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_stall2_rdy", in0_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hB1, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "bp_resume", 72'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_resume_rdy", in0_ready, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hB2, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "bp_o1", 72'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hB3, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "bp_o2", 72'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 72'hB4, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "bp_o3", 72'hB3, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b0);
        checkBeat(1'b0, "bp_o4", 72'hB4, 1'b0, 1'b1, 1'b0, 1'b0);
        applyIdle();
        checkBeat(1'b0, "bp_o4_held", 72'hB4, 1'b0, 1'b1, 1'b0, 1'b0);
        applyIdle();
        checkOutput("bp_drain", out_valid, 1'b0);

        // Stray non-sop beats on both sources in IDLE, then a normal packet.
        applyStimulus(1'b1, 1'b0, 1'b0, 72'hE0, 1'b1, 1'b0, 1'b0, 72'hE1, 1'b1);
        checkOutput("stray_rdy0", in0_ready, 1'b1);
        checkOutput("stray_rdy1", in1_ready, 1'b1);
        checkOutput("stray_pre_pulse", stray_pulse, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 72'hF0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkOutput("stray_pulse", stray_pulse, 1'b1);
        checkOutput("stray_no_out", out_valid, 1'b0);
        checkOutput("stray_sop_rdy", in0_ready, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 72'hF0, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkOutput("stray_pulse_end", stray_pulse, 1'b0);
        checkOutput("stray_no_out2", out_valid, 1'b0);
        checkOutput("stray_grant_rdy", in0_ready, 1'b1);
        applyIdle();
        checkBeat(1'b0, "stray_pkt", 72'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyIdle();
        checkOutput("stray_drain", out_valid, 1'b0);

        // Reset asserted mid-packet after two of six beats.
        applyStimulus(1'b1, 1'b1, 1'b0, 72'h90, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 72'h90, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'h91, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "mid_o0", 72'h90, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 72'h92, 1'b0, 1'b0, 1'b0, 72'h0, 1'b1);
        checkBeat(1'b0, "mid_o1", 72'h91, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_pre_rdy", in0_ready, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 1'b0);
        checkOutput("mid_rst_data", out_data, 72'h0);
        checkOutput("mid_rst_rdy0", in0_ready, 1'b0);
        checkOutput("mid_rst_rdy1", in1_ready, 1'b0);
        applyIdle();
        checkOutput("mid_rst_hold", out_valid, 1'b0);
        reset_n = 1'b1;

        // Contention: both sources keep sop beats waiting; grants must go
        // 0,1,0,1 with whole packets and one idle output cycle between them.
        for (int p = 0; p < 4; p++) begin
            logic g;
            logic ov;
            g  = ((p % 2) == 1);
            ov = (p < 3);
            presentPair(g, 1'b1, 1'b0, mkData(p, 0), ov, mkData(p + 1, 0));
            checkOutput("arb_rdy0", in0_ready, 1'b0);
            checkOutput("arb_rdy1", in1_ready, 1'b0);
            if (p > 0) checkBeat(1'b0, "arb_prev", mkData(p - 1, 2), 1'b0, 1'b1, ~g, 1'b0);
            else       checkOutput("arb_first_valid", out_valid, 1'b0);
            for (int b = 0; b < 3; b++) begin
                presentPair(g, (b == 0), (b == 2), mkData(p, b), ov, mkData(p + 1, 0));
                checkOutput("xfer_rdy_gnt", g ? in1_ready : in0_ready, 1'b1);
                checkOutput("xfer_rdy_other", g ? in0_ready : in1_ready, 1'b0);
                if (b == 0) checkOutput("xfer_gap", out_valid, 1'b0);
                else        checkBeat(1'b0, "xfer_beat", mkData(p, b - 1), (b == 1), 1'b0, g, 1'b0);
            end
        end
        applyIdle();
        checkBeat(1'b0, "arb_last", mkData(3, 2), 1'b0, 1'b1, 1'b1, 1'b0);
        applyIdle();
        checkOutput("arb_drain", out_valid, 1'b0);

        // Truncation on dut_t (MAX_BEATS=4): in1 sends 7 beats, eop on the 7th.
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b1, 1'b0, 72'h70, 1'b1);
        checkOutput("tr_bubble_rdy", t_in1_ready, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b1, 1'b0, 72'h70, 1'b1);
        checkOutput("tr_b0_rdy", t_in1_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b0, 1'b0, 72'h71, 1'b1);
        checkBeat(1'b1, "tr_o0", 72'h70, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b0, 1'b0, 72'h72, 1'b1);
        checkBeat(1'b1, "tr_o1", 72'h71, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b0, 1'b0, 72'h73, 1'b1);
        checkBeat(1'b1, "tr_o2", 72'h72, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("tr_pre_pulse", t_trunc_pulse, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b0, 1'b0, 72'h74, 1'b0);
        checkBeat(1'b1, "tr_o3", 72'h73, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("tr_pulse", t_trunc_pulse, 1'b1);
        checkOutput("tr_drop_rdy_stalled", t_in1_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b0, 1'b0, 72'h75, 1'b1);
        checkBeat(1'b1, "tr_o3_held", 72'h73, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("tr_pulse_end", t_trunc_pulse, 1'b0);
        checkOutput("tr_drop_rdy", t_in1_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b0, 1'b1, 72'h76, 1'b1);
        checkOutput("tr_drop_no_out", t_out_valid, 1'b0);
        checkOutput("tr_drop_rdy_eop", t_in1_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 72'h0, 1'b1, 1'b1, 1'b0, 72'h77, 1'b1);
        checkOutput("tr_idle_no_out", t_out_valid, 1'b0);
        checkOutput("tr_idle_rdy", t_in1_ready, 1'b0);
        checkOutput("tr_no_stray", t_stray_pulse, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_10g_rx_st_lane_arbiter.md
Name: eth_10g_rx_st_lane_arbiter

Overview:
- Two-requester, packet-locked, round-robin arbiter that shares one 72-bit Avalon-ST channel (64 data + 8 control, lane-decoder format) feeding the 10G MAC RX path.
- Grant is held from sop to eop. A watchdog truncates runaway packets so one requester cannot starve the other.
- Output is a single registered stage with full ready/valid backpressure, replacing the always-ready timing adapter used today.

Parameters:
- DATA_W, 72, beat payload width.
- MAX_BEATS, 1200, maximum accepted beats per packet before forced truncation (9600 B jumbo).
- CNT_W, $clog2(MAX_BEATS+1), beat counter width (derived; do not override).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- in0_valid, in1_valid  in  1 each  requester beat valid.
- in0_ready, in1_ready  out  1 each  requester beat accepted.
- in0_data, in1_data  in  DATA_W each  requester payload.
- in0_sop, in0_eop, in1_sop, in1_eop  in  1 each  packet delimiters.
- out_valid  out  1  registered beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  registered payload.
- out_sop, out_eop  out  1 each  registered delimiters.
- out_channel  out  1  source index of the current output beat.
- out_error  out  1  set on the truncated final beat.
- stray_pulse  out  1  one-cycle pulse when a non-sop beat is discarded in IDLE.
- trunc_pulse  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, rr_last=1 (so requester 0 wins first).
  - out_valid=0; out_data, out_sop, out_eop, out_channel, out_error = 0.
  - beat_cnt=0, both in_ready=0, both pulses=0.
- Slot free: `slot_free = !out_valid || out_ready`. An input accept occurs when `inX_valid && inX_ready`.
- State IDLE:
  - The requests are `reqX = inX_valid && inX_sop`.
  - One request: grant it.
  - Both requesting: grant `!rr_last`.
  - On grant, register `gnt` and `rr_last = gnt`, then go to XFER. No beat is accepted in this cycle (1-cycle arbitration bubble).
  - Any `inX_valid && !inX_sop` in IDLE: inX_ready=1, beat discarded, stray_pulse=1. Both sources stray in the same cycle gives a single pulse.
  - A source with sop=1 is never discarded.
- State XFER:
  - `in[gnt]_ready = slot_free`; the other in_ready=0.
  - Each accept loads the output register with the beat, sets out_channel=gnt and out_error=0, and increments beat_cnt.
  - Accepted beat with eop=1: beat_cnt clears to 0 and state goes to IDLE.
  - Accepted beat with eop=0 and beat_cnt+1==MAX_BEATS: the beat is emitted with out_eop=1 and out_error=1, trunc_pulse=1, beat_cnt clears, state goes to DROP.
  - A second sop mid-packet is passed through unchanged (no check).
- State DROP:
  - `in[gnt]_ready=1` regardless of out_ready; beats are discarded with no output.
  - Leave for IDLE on an accepted beat with eop=1.
- Output register behaviour:
  - out_valid is set on accept.
  - It clears when `out_ready && !accept`.
  - It holds while `!out_ready`; out_data and sideband stay stable while `out_valid && !out_ready`.
- Latency: input accept to out_valid is 1 cycle. Back-to-back beats sustain 1 beat/clk while out_ready=1.
- Packet-to-packet turnaround costs 1 bubble cycle (the IDLE arbitration).
- Simultaneous eop-accept and a pending request from the other source: that request is arbitrated in the next (IDLE) cycle.
- Reset mid-packet: everything returns to reset values and any partial packet on the output is lost. Upstream must restart at sop.
- in_ready never depends combinationally on the same requester's valid; it depends only on state, gnt and out_valid/out_ready.

Test Plan:
- Single source: in0 sends a 4-beat packet (sop on beat 0, eop on beat 3), out_ready=1.
  - Arbitration bubble, then out_valid high for 4 consecutive cycles with out_channel=0.
  - Data matches input; out_sop on beat 0, out_eop on beat 3, out_error=0.
- Contention: both sources hold 3-beat packets continuously.
  - Grants alternate 0,1,0,1; each packet is contiguous, never interleaved.
  - One idle cycle appears between packets.
- Backpressure: out_ready toggles 1,0,0,1 during a 5-beat packet.
  - out_data/out_eop stable during stalls; in0_ready=0 while `out_valid && !out_ready`.
  - All 5 beats delivered in order.
- Truncation: MAX_BEATS=4; in1 sends 7 beats with eop on beat 7.
  - Output shows 4 beats, beat 4 with out_eop=1 and out_error=1; trunc_pulse=1 once.
  - Beats 5–7 are accepted with no output, then return to IDLE.
- Stray: in0 presents valid with sop=0 in IDLE.
  - Beat is accepted and discarded, stray_pulse=1 for 1 cycle, no output.
  - A following sop beat is granted normally.
- Reset mid-packet: assert reset_n=0 after beat 2 of 6.
  - out_valid=0 and both in_ready=0 asynchronously.
  - After release, requester 0 wins the first contention.
